// File: rtl/fetch_engine.sv
// fetch_engine: moves one cache line between the local line memory and the backing bus.
// Build option FETCH_WB_FILL_EN: cmd 2'b10 writes the slot back to fetch_addr, then refills it from fill_addr.
module fetch_engine #(
   parameter int addr_width = 32,
   parameter int list_depth = 4,
   parameter int data_width = 32,
   parameter int list_width = 32
) (
   input  logic                                                 clk,
   input  logic                                                 rst_n,
   input  logic                                                 fetch_req,
   output logic                                                 fetch_gnt,
   input  logic [1:0]                                           fetch_cmd,
   input  logic [$clog2(list_depth)-1:0]                        fetch_tag,
   input  logic [addr_width-1:0]                                fetch_addr,
`ifdef FETCH_WB_FILL_EN
   input  logic [addr_width-1:0]                                fill_addr,
`endif
   output logic                                                 fetch_done,
   output logic                                                 lm_ren,
   output logic [$clog2(list_depth)+$clog2(list_width)-1:0]     lm_raddr,
   input  logic [data_width-1:0]                                lm_rdata,
   output logic                                                 lm_wen,
   output logic [$clog2(list_depth)+$clog2(list_width)-1:0]     lm_waddr,
   output logic [data_width-1:0]                                lm_wdata,
   input  logic                                                 lm_wready,
   output logic                                                 bus_req,
   output logic                                                 bus_we,
   output logic [addr_width-1:0]                                bus_addr,
   output logic [data_width-1:0]                                bus_wdata,
   input  logic                                                 bus_gnt,
   input  logic                                                 bus_rvalid,
   input  logic [data_width-1:0]                                bus_rdata
);
   localparam int TW  = $clog2(list_depth);
   localparam int CW  = $clog2(list_width);
   localparam int OFF = $clog2(list_width * data_width / 8);
   localparam logic [CW-1:0] LAST = CW'(list_width - 1);
   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] WB_RD     = 3'd1;
   localparam logic [2:0] WB_BUS    = 3'd2;
   localparam logic [2:0] FILL_BUS  = 3'd3;
   localparam logic [2:0] FILL_WAIT = 3'd4;
   localparam logic [2:0] FILL_WR   = 3'd5;
   localparam logic [2:0] DONE      = 3'd6;
   logic [2:0]                r_state;
   logic [TW-1:0]             r_tag;
   logic [addr_width-OFF-1:0] r_base;
   logic [CW-1:0]             r_cnt;
   logic [data_width-1:0]     r_data;
   logic                      r_pend;
   logic                      w_last;
   logic                      w_req_comb;
   logic                      w_to_fill;
   logic [addr_width-OFF-1:0] w_line;
   logic                      w_unused;
   assign w_last = r_cnt == LAST;
`ifdef FETCH_WB_FILL_EN
   logic [1:0]                r_cmd;
   logic                      r_phase;
   logic [addr_width-OFF-1:0] r_fbase;
   // combined command: remember the fill line and switch the bus address once the write-back is done
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd   <= '0;
         r_phase <= 1'b0;
         r_fbase <= '0;
      end else if (r_state == IDLE && fetch_req) begin
         r_cmd   <= fetch_cmd;
         r_phase <= 1'b0;
         r_fbase <= fill_addr[addr_width-1:OFF];
      end else if (r_state == WB_BUS && bus_gnt && w_last && w_to_fill) begin
         r_phase <= 1'b1;
      end
   end
   assign w_req_comb = fetch_cmd == 2'b10;
   assign w_to_fill  = r_cmd == 2'b10;
   assign w_line     = r_phase ? r_fbase : r_base;
   assign w_unused   = ^{fetch_addr[OFF-1:0], fill_addr[OFF-1:0]};
`else
   assign w_req_comb = 1'b0;
   assign w_to_fill  = 1'b0;
   assign w_line     = r_base;
   assign w_unused   = ^fetch_addr[OFF-1:0];
`endif
   // request capture, FSM sequencing, word counter and data capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_tag   <= '0;
         r_base  <= '0;
         r_cnt   <= '0;
         r_data  <= '0;
         r_pend  <= 1'b0;
      end else begin
         r_pend <= r_state == WB_RD;
         case (r_state)
            IDLE: if (fetch_req) begin
               r_tag   <= fetch_tag;
               r_base  <= fetch_addr[addr_width-1:OFF];
               r_cnt   <= '0;
               r_state <= (fetch_cmd == 2'b00 || w_req_comb) ? WB_RD : fetch_cmd == 2'b01 ? FILL_BUS : DONE;
            end
            WB_RD: r_state <= WB_BUS;
            WB_BUS: begin
               if (r_pend) r_data <= lm_rdata;
               if (bus_gnt) begin
                  r_cnt   <= !w_last ? r_cnt + 1'b1 : w_to_fill ? '0 : r_cnt;
                  r_state <= !w_last ? WB_RD : w_to_fill ? FILL_BUS : DONE;
               end
            end
            FILL_BUS: if (bus_gnt) r_state <= FILL_WAIT;
            FILL_WAIT: if (bus_rvalid) begin
               r_data  <= bus_rdata;
               r_state <= FILL_WR;
            end
            FILL_WR: if (lm_wready) begin
               r_cnt   <= w_last ? r_cnt : r_cnt + 1'b1;
               r_state <= w_last ? DONE : FILL_BUS;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   // the line-memory word arrives one cycle after lm_ren, so forward it while it is not yet captured
   assign fetch_gnt  = rst_n && r_state == IDLE;
   assign fetch_done = r_state == DONE;
   assign lm_ren     = r_state == WB_RD;
   assign lm_raddr   = {r_tag, r_cnt};
   assign lm_wen     = r_state == FILL_WR;
   assign lm_waddr   = {r_tag, r_cnt};
   assign lm_wdata   = r_data;
   assign bus_req    = r_state == WB_BUS || r_state == FILL_BUS;
   assign bus_we     = r_state == WB_BUS;
   assign bus_addr   = addr_width'({w_line, r_cnt}) << (OFF - CW);
   assign bus_wdata  = r_pend ? lm_rdata : r_data;
endmodule

// File: tb/tb_fetch_engine.sv
// tb_fetch_engine: vector table, corner sequences and random traffic against a line-transfer model.
module tb_fetch_engine;
   localparam int CW = 5;
`ifdef FETCH_WB_FILL_EN
   localparam bit COMB = 1'b1;
`else
   localparam bit COMB = 1'b0;
`endif
   typedef struct {
      logic [1:0]  cmd;
      logic [1:0]  tag;
      logic [31:0] addr;
      logic [31:0] faddr;
      int          cyc;
   } vec_t;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        fetch_req = 1'b0, fetch_gnt, fetch_done;
   logic [1:0]  fetch_cmd = '0, fetch_tag = '0;
   logic [31:0] fetch_addr = '0, fill_addr = '0;
   logic        lm_ren, lm_wen, lm_wready;
   logic [6:0]  lm_raddr, lm_waddr;
   logic [31:0] lm_rdata = '0, lm_wdata;
   logic        bus_req, bus_we, bus_gnt, bus_rvalid = 1'b0;
   logic [31:0] bus_addr, bus_wdata, bus_rdata = '0;
   logic        gnt_en = 1'b1, stall_last = 1'b0, rnd = 1'b0, rnd_g = 1'b1, rnd_w = 1'b1;
   logic [31:0] lmem [128];
   logic [31:0] bw_a[$], bw_d[$], br_a[$], lw_a[$], lw_d[$], lr_a[$];
   logic [31:0] ex_bw_a[$], ex_bw_d[$], ex_br_a[$], ex_lw_a[$], ex_lw_d[$], ex_lr_a[$];
   int total = 0, bad = 0, n_done = 0, n_viol = 0;

   always #5 clk = ~clk;

   fetch_engine dut (
      .clk(clk), .rst_n(rst_n),
      .fetch_req(fetch_req), .fetch_gnt(fetch_gnt), .fetch_cmd(fetch_cmd), .fetch_tag(fetch_tag),
      .fetch_addr(fetch_addr),
`ifdef FETCH_WB_FILL_EN
      .fill_addr(fill_addr),
`endif
      .fetch_done(fetch_done),
      .lm_ren(lm_ren), .lm_raddr(lm_raddr), .lm_rdata(lm_rdata),
      .lm_wen(lm_wen), .lm_waddr(lm_waddr), .lm_wdata(lm_wdata), .lm_wready(lm_wready),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
   );

   function automatic logic [31:0] rd_val(input logic [31:0] a);
      return (a - 32'h1000) >> 2;
   endfunction

   assign bus_gnt   = bus_req && gnt_en && (!rnd || rnd_g);
   assign lm_wready = lm_wen && (!rnd || rnd_w) && !(stall_last && lm_waddr[CW-1:0] == 5'd31);

   // bus read data and line-memory read data each come back one cycle after their request
   always @(posedge clk) begin
      bus_rvalid <= bus_req && bus_gnt && !bus_we;
      bus_rdata  <= (bus_req && bus_gnt && !bus_we) ? rd_val(bus_addr) : 32'hBAD0_BAD0;
      lm_rdata   <= lm_ren ? lmem[lm_raddr] : 32'hDEAD_BEEF;
   end

   always @(posedge clk) begin
      #1;
      rnd_g = $urandom_range(0, 2) != 0;
      rnd_w = $urandom_range(0, 2) != 0;
   end

   // record every completed handshake
   always @(negedge clk) begin
      if (fetch_done) n_done++;
      if (bus_req && lm_wen) n_viol++;
      if (lm_ren) lr_a.push_back(32'(lm_raddr));
      if (bus_req && bus_gnt && bus_we) begin
         bw_a.push_back(bus_addr);
         bw_d.push_back(bus_wdata);
      end
      if (bus_req && bus_gnt && !bus_we) br_a.push_back(bus_addr);
      if (lm_wen && lm_wready) begin
         lw_a.push_back(32'(lm_waddr));
         lw_d.push_back(lm_wdata);
         lmem[lm_waddr] = lm_wdata;
      end
   end

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic cmp_q(input string nm, input logic [31:0] got[$], input logic [31:0] exp[$]);
      chk({nm, "_len"}, 128'(got.size()), 128'(exp.size()));
      for (int i = 0; i < got.size() && i < exp.size(); i++)
         chk($sformatf("%s[%0d]", nm, i), 128'(got[i]), 128'(exp[i]));
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_ctl"}, 128'({bus_req, bus_we, lm_ren, lm_wen, fetch_done}), 128'(0));
      chk({nm, "_bus"}, 128'({bus_addr, bus_wdata}), 128'(0));
      chk({nm, "_lm"}, 128'({lm_raddr, lm_waddr, lm_wdata}), 128'(0));
   endtask

   // build the expected traffic from the command semantics, then issue the request
   task automatic start_txn(input vec_t v);
      logic [31:0] wb, fb;
      logic [31:0] t;
      wb = v.addr & ~32'h7F;
      fb = (v.cmd == 2'b01 ? v.addr : v.faddr) & ~32'h7F;
      t  = 32'(v.tag) * 32;
      bw_a.delete(); bw_d.delete(); br_a.delete(); lw_a.delete(); lw_d.delete(); lr_a.delete();
      ex_bw_a.delete(); ex_bw_d.delete(); ex_br_a.delete(); ex_lw_a.delete(); ex_lw_d.delete(); ex_lr_a.delete();
      n_done = 0;
      n_viol = 0;
      if (v.cmd == 2'b00 || (v.cmd == 2'b10 && COMB))
         for (int i = 0; i < 32; i++) begin
            ex_lr_a.push_back(t + 32'(i));
            ex_bw_a.push_back(wb + 32'(4 * i));
            ex_bw_d.push_back(lmem[t + 32'(i)]);
         end
      if (v.cmd == 2'b01 || (v.cmd == 2'b10 && COMB))
         for (int i = 0; i < 32; i++) begin
            ex_br_a.push_back(fb + 32'(4 * i));
            ex_lw_a.push_back(t + 32'(i));
            ex_lw_d.push_back(rd_val(fb + 32'(4 * i)));
         end
      @(posedge clk); #1;
      fetch_req  = 1'b1;
      fetch_cmd  = v.cmd;
      fetch_tag  = v.tag;
      fetch_addr = v.addr;
      fill_addr  = v.faddr;
      @(negedge clk);
      chk("gnt_idle", 128'(fetch_gnt), 128'(1));
      @(posedge clk); #1;
      fetch_req  = 1'b0;
      fetch_cmd  = 2'($urandom);
      fetch_tag  = 2'($urandom);
      fetch_addr = $urandom;
      fill_addr  = $urandom;
   endtask

   task automatic finish_txn(input int exp_cyc);
      int cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!fetch_done && cyc < 3000);
      chk("done_seen", 128'(fetch_done), 128'(1));
      if (exp_cyc > 0) chk("latency", 128'(cyc), 128'(exp_cyc));
      @(negedge clk);
      chk("done_1cyc", 128'(fetch_done), 128'(0));
      chk("gnt_back", 128'(fetch_gnt), 128'(1));
      chk("done_cnt", 128'(n_done), 128'(1));
      chk("req_wen_overlap", 128'(n_viol), 128'(0));
      cmp_q("lm_raddr", lr_a, ex_lr_a);
      cmp_q("bus_wr_addr", bw_a, ex_bw_a);
      cmp_q("bus_wr_data", bw_d, ex_bw_d);
      cmp_q("bus_rd_addr", br_a, ex_br_a);
      cmp_q("lm_waddr", lw_a, ex_lw_a);
      cmp_q("lm_wdata", lw_d, ex_lw_d);
   endtask

   initial begin
      vec_t vt[6];
      vec_t h;
      int   cyc;
      for (int k = 0; k < 128; k++) lmem[k] = (k / 32 == 1) ? 32'hA0 + 32'(k % 32) : $urandom;
      vt[0] = '{2'b01, 2'd2, 32'h0000_1044, 32'h0, 97};
      vt[1] = '{2'b00, 2'd1, 32'h0000_1000, 32'h0, 65};
      vt[2] = '{2'b11, 2'd3, 32'h0000_2000, 32'h5000, 1};
      vt[3] = '{2'b10, 2'd0, 32'h0000_3000, 32'h0000_1080, COMB ? 161 : 1};
      vt[4] = '{2'b01, 2'd3, 32'hFFFF_FFFF, 32'h0, 97};
      vt[5] = '{2'b00, 2'd0, 32'hFFFF_FF80, 32'h0, 65};
      repeat (2) @(negedge clk);
      chk_zero("reset");
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("gnt_after_reset", 128'(fetch_gnt), 128'(1));
      for (int i = 0; i < 6; i++) begin
         start_txn(vt[i]);
         finish_txn(vt[i].cyc);
      end
      // grant withheld for 5 cycles on the first fill word
      gnt_en = 1'b0;
      h = '{2'b01, 2'd2, 32'h0000_4ABC, 32'h0, 0};
      start_txn(h);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_req", 128'(bus_req), 128'(1));
         chk("stall_addr", 128'(bus_addr), 128'(32'h4A80));
         chk("stall_cnt", 128'(lm_waddr), 128'(64));
      end
      @(posedge clk); #1 gnt_en = 1'b1;
      finish_txn(97);
      // lm_wready withheld 3 cycles on the last fill word
      stall_last = 1'b1;
      h = '{2'b01, 2'd1, 32'h0000_2000, 32'h0, 0};
      start_txn(h);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!(lm_wen && lm_waddr[CW-1:0] == 5'd31) && cyc < 500);
      chk("last_wen", 128'(lm_wen), 128'(1));
      repeat (2) begin
         @(negedge clk);
         chk("last_wen_hold", 128'(lm_wen), 128'(1));
         chk("last_no_done", 128'(fetch_done), 128'(0));
      end
      @(posedge clk); #1 stall_last = 1'b0;
      finish_txn(2);
      // reset in the middle of a write-back
      h = '{2'b00, 2'd1, 32'h0000_1000, 32'h0, 0};
      start_txn(h);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (bw_a.size() < 10 && cyc < 500);
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk);
      chk_zero("rst_mid");
      repeat (3) @(negedge clk);
      chk("rst_no_done", 128'(n_done), 128'(0));
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_gnt", 128'(fetch_gnt), 128'(1));
      h = '{2'b01, 2'd0, 32'h0000_1000, 32'h0, 97};
      start_txn(h);
      finish_txn(97);
      // random commands with random bus grant and write-ready stalls
      rnd = 1'b1;
      for (int n = 0; n < 12; n++) begin
         h.cmd   = 2'($urandom);
         h.tag   = 2'($urandom);
         h.addr  = $urandom;
         h.faddr = $urandom;
         h.cyc   = 0;
         start_txn(h);
         finish_txn(0);
      end
      rnd = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
